// File: rtl/if_pkg.sv
// Shared constants for the instruction-fetch stage: reset PC, NOP encoding and IF->ID bus width.
package if_pkg;

  localparam logic [31:0] IF_RESET_PC = 32'h1c000000;
  localparam logic [31:0] NOP_INST    = 32'h03400000;

  // pc + inst + adef flag
  function automatic int fs_to_ds_bus_w(input int pc_w, input int inst_w);
    return pc_w + inst_w + 1;
  endfunction

  localparam int FS_TO_DS_BUS_W = fs_to_ds_bus_w(32, 32);

endpackage

// File: rtl/if_fetch_unit_inst_buf.sv
// One-entry hold buffer: keeps the SRAM word alive while ID stalls; zero added latency.
// Captures on the first stall cycle, clears whenever IF advances.
module if_inst_buf #(
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fs_valid,
  input  logic              fs_allowin,
  input  logic [INST_W-1:0] sram_rdata,
  output logic [INST_W-1:0] inst
);

  logic              buf_valid;
  logic [INST_W-1:0] inst_buf;

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      inst_buf  <= '0;
    end else if (fs_allowin) begin
      buf_valid <= 1'b0;
    end else if (fs_valid && !buf_valid) begin
      // SRAM data is only valid the cycle after a request, so grab it now
      inst_buf  <= sram_rdata;
      buf_valid <= 1'b1;
    end
  end

  assign inst = buf_valid ? inst_buf : sram_rdata;

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: PC generation, sync-SRAM request, 1-cycle fetch latency, stalls hold the offered word.
// Optional alignment check under IF_ADEF_CHECK_EN; redirects during a stall are remembered.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(IF_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  input  logic              ds_allowin,
  output logic              fs_to_ds_valid,
  output logic [PC_W-1:0]   fs_to_ds_pc,
  output logic [INST_W-1:0] fs_to_ds_inst,
  output logic              fs_to_ds_adef,
  output logic              inst_sram_en,
  output logic [PC_W-1:0]   inst_sram_addr,
  input  logic [INST_W-1:0] inst_sram_rdata
);

  logic              fs_valid;
  logic [PC_W-1:0]   fs_pc;
  logic              br_pending;
  logic [PC_W-1:0]   br_target_r;
  logic              fs_cancel;
  logic              fs_ready_go;
  logic              fs_allowin;
  logic [PC_W-1:0]   nextpc;
  logic [INST_W-1:0] buf_inst;

  assign fs_ready_go = 1'b1;
  assign fs_allowin  = !fs_valid || (fs_ready_go && ds_allowin);

  always_comb begin
    if (br_taken)        nextpc = br_target;
    else if (br_pending) nextpc = br_target_r;
    else                 nextpc = fs_pc + PC_W'(4);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid    <= 1'b0;
      fs_pc       <= RESET_PC - PC_W'(4);
      br_pending  <= 1'b0;
      br_target_r <= '0;
      fs_cancel   <= 1'b0;
    end else if (fs_allowin) begin
      fs_valid   <= 1'b1;
      fs_pc      <= nextpc;
      br_pending <= 1'b0;
      fs_cancel  <= 1'b0;
    end else if (br_taken) begin
      // stalled redirect: park the target and kill the wrong-path word
      br_pending  <= 1'b1;
      br_target_r <= br_target;
      if (fs_valid) fs_cancel <= 1'b1;
    end
  end

  if_inst_buf #(.INST_W(INST_W)) u_inst_buf (
    .clk        (clk),
    .reset      (reset),
    .fs_valid   (fs_valid),
    .fs_allowin (fs_allowin),
    .sram_rdata (inst_sram_rdata),
    .inst       (buf_inst)
  );

  assign inst_sram_addr = nextpc;
  assign fs_to_ds_valid = fs_valid && !fs_cancel && !br_taken;
  assign fs_to_ds_pc    = fs_pc;

`ifdef IF_ADEF_CHECK_EN
  logic nextpc_adef;
  logic fs_adef;

  assign nextpc_adef = nextpc[1:0] != 2'b00;

  always_ff @(posedge clk) begin
    if (reset)           fs_adef <= 1'b0;
    else if (fs_allowin) fs_adef <= nextpc_adef;
  end

  assign inst_sram_en  = !reset && fs_allowin && !nextpc_adef;
  assign fs_to_ds_adef = fs_adef;
  assign fs_to_ds_inst = fs_adef ? INST_W'(NOP_INST) : buf_inst;
`else
  assign inst_sram_en  = !reset && fs_allowin;
  assign fs_to_ds_adef = 1'b0;
  assign fs_to_ds_inst = buf_inst;
`endif

endmodule
